cub_interconnect_tx: RTL and testbench

//  Transmit side of the cubank interconnect. Each write to a cubank's interconnect register
//  (R17) produces a one-cycle write strobe; this block captures that word in a small FIFO.
//  It pops words in order into a 4-tap shift chain that drives the neighbour cubank's

---
 rtl/cub_interconnect_tx_if.sv | 35 +++
 rtl/cub_interconnect_tx.sv | 124 ++++++++++++
 tb/tb_cub_interconnect_tx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cub_interconnect_tx_if.sv
// Link bundle between a source cubank's R17 write port and the neighbour's tap inputs.
// The master drives the strobe, accept and flush signals; the slave is the transmit block.
interface cub_interconnect_tx_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] cub_interconnect_reg_i;
    logic                  cub_interconnect_wr_i;
    logic                  dst_accept_i;
    logic                  flush_i;
    logic                  cub_interconnect_valid_o;
    logic [DATA_WIDTH-1:0] tap_reg_0_o;
    logic [DATA_WIDTH-1:0] tap_reg_1_o;
    logic [DATA_WIDTH-1:0] tap_reg_2_o;
    logic [DATA_WIDTH-1:0] tap_reg_3_o;
    logic [CW-1:0]         fifo_cnt_o;
    logic                  fifo_full_o;
    logic                  overflow_o;
    logic                  busy_o;
    logic                  timeout_o;

    modport master (
        output cub_interconnect_reg_i, cub_interconnect_wr_i, dst_accept_i, flush_i,
        input  cub_interconnect_valid_o, tap_reg_0_o, tap_reg_1_o, tap_reg_2_o, tap_reg_3_o,
        input  fifo_cnt_o, fifo_full_o, overflow_o, busy_o, timeout_o
    );

    modport slave (
        input  cub_interconnect_reg_i, cub_interconnect_wr_i, dst_accept_i, flush_i,
        output cub_interconnect_valid_o, tap_reg_0_o, tap_reg_1_o, tap_reg_2_o, tap_reg_3_o,
        output fifo_cnt_o, fifo_full_o, overflow_o, busy_o, timeout_o
    );
endinterface

// File: rtl/cub_interconnect_tx.sv
// Transmit side of a cubank interconnect link: buffers R17 write strobes in a FIFO and
// shifts popped words into a 4-tap chain feeding the neighbour cubank.
module cub_interconnect_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STALL_MAX  = 255
) (
    input logic                  clk,
    input logic                  rst_n,
    cub_interconnect_tx_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {StIdle, StSend, StStall} state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] tap_q [4];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         stall_q, stall_d;
    state_e                state_q, state_d;
    logic                  valid_q, overflow_q, overflow_d, timeout_q, timeout_d;
    logic                  flush, full, push, pop, drop;

    assign flush = bus.flush_i;
    assign full  = (cnt_q == CW'(DEPTH));
    // Pop decision uses the registered count, so a word can never leave on its push edge.
    assign pop   = !flush && (cnt_q != '0) && bus.dst_accept_i;
    assign push  = !flush && bus.cub_interconnect_wr_i && (!full || pop);
    assign drop  = !flush && bus.cub_interconnect_wr_i && full && !pop;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        overflow_d = flush ? 1'b0 : (overflow_q | drop);
        timeout_d  = flush ? 1'b0 : (timeout_q | (stall_q == SW'(STALL_MAX)));
        if (cnt_d == '0) begin
            state_d = StIdle;
            stall_d = '0;
        end else if (pop || state_q == StIdle) begin
            state_d = StSend;
            stall_d = '0;
        end else begin
            state_d = StStall;
            if (stall_q != SW'(STALL_MAX)) begin
                stall_d = stall_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            stall_q    <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            cnt_q      <= cnt_d;
            valid_q    <= pop;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                for (int i = 0; i < 4; i++) begin
                    tap_q[i] <= '0;
                end
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    tap_q[0] <= mem_q[rd_ptr_q];
                    tap_q[1] <= tap_q[0];
                    tap_q[2] <= tap_q[1];
                    tap_q[3] <= tap_q[2];
                end
            end
        end
    end

    // Storage needs no reset: the count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.cub_interconnect_reg_i;
        end
    end

    assign bus.cub_interconnect_valid_o = valid_q;
    assign bus.tap_reg_0_o              = tap_q[0];
    assign bus.tap_reg_1_o              = tap_q[1];
    assign bus.tap_reg_2_o              = tap_q[2];
    assign bus.tap_reg_3_o              = tap_q[3];
    assign bus.fifo_cnt_o               = cnt_q;
    assign bus.fifo_full_o              = full;
    assign bus.overflow_o               = overflow_q;
    assign bus.busy_o                   = (state_q != StIdle);
    assign bus.timeout_o                = timeout_q;
endmodule

// File: tb/tb_cub_interconnect_tx.sv
// Directed bench for cub_interconnect_tx: a scoreboard queue holds the words expected on
// the tap chain, and a negedge monitor retires one entry per valid pulse.
module tb_cub_interconnect_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cub_interconnect_tx_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();

    cub_interconnect_tx #(
        .DATA_WIDTH(32),
        .DEPTH     (4),
        .STALL_MAX (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          valid_seen = 0;
    int          v0;
    logic [31:0] exp_q[$];
    logic [31:0] shadow [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] d, input bit kept);
        bus.cub_interconnect_reg_i = d;
        bus.cub_interconnect_wr_i  = 1'b1;
        if (kept) exp_q.push_back(d);
        tick();
        bus.cub_interconnect_wr_i = 1'b0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < 4; i++) shadow[i] = '0;
    endtask

    task automatic do_flush();
        bus.flush_i = 1'b1;
        clear_model();
        tick();
        bus.flush_i = 1'b0;
    endtask

    task automatic chk_taps(input string tag, input logic [31:0] t0, input logic [31:0] t1,
                            input logic [31:0] t2, input logic [31:0] t3);
        chk({tag, "_tap0"}, 64'(bus.tap_reg_0_o), 64'(t0));
        chk({tag, "_tap1"}, 64'(bus.tap_reg_1_o), 64'(t1));
        chk({tag, "_tap2"}, 64'(bus.tap_reg_2_o), 64'(t2));
        chk({tag, "_tap3"}, 64'(bus.tap_reg_3_o), 64'(t3));
    endtask

    // Every valid pulse must retire the oldest outstanding word into tap0.
    always @(negedge clk) begin
        if (rst_n && bus.cub_interconnect_valid_o === 1'b1) begin
            valid_seen++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL valid_unexpected observed=pulse expected=none");
            end
            if (exp_q.size() != 0) begin
                shadow[3] = shadow[2];
                shadow[2] = shadow[1];
                shadow[1] = shadow[0];
                shadow[0] = exp_q.pop_front();
                chk_taps("pop", shadow[0], shadow[1], shadow[2], shadow[3]);
            end
        end
    end

    initial begin
        bus.cub_interconnect_reg_i = '0;
        bus.cub_interconnect_wr_i  = 1'b0;
        bus.dst_accept_i           = 1'b0;
        bus.flush_i                = 1'b0;
        clear_model();
        #3;
        chk_taps("rst", 0, 0, 0, 0);
        chk("rst_cnt", 64'(bus.fifo_cnt_o), 0);
        chk("rst_busy", 64'(bus.busy_o), 0);
        chk("rst_valid", 64'(bus.cub_interconnect_valid_o), 0);
        chk("rst_ovf", 64'(bus.overflow_o), 0);
        chk("rst_tmo", 64'(bus.timeout_o), 0);
        #9 rst_n = 1'b1;
        tick();

        // Single word: valid only in the cycle after the pop edge.
        bus.dst_accept_i = 1'b1;
        strobe(32'hA5A5_0001, 1'b1);
        chk("t2_valid_e0", 64'(bus.cub_interconnect_valid_o), 0);
        chk("t2_cnt_e0", 64'(bus.fifo_cnt_o), 1);
        chk("t2_busy_e0", 64'(bus.busy_o), 1);
        tick();
        chk("t2_valid_e1", 64'(bus.cub_interconnect_valid_o), 1);
        chk("t2_tap0", 64'(bus.tap_reg_0_o), 64'h A5A5_0001);
        chk("t2_cnt_e1", 64'(bus.fifo_cnt_o), 0);
        tick();
        chk("t2_valid_e2", 64'(bus.cub_interconnect_valid_o), 0);

        // Ordering and shift chain.
        v0 = valid_seen;
        for (int i = 1; i <= 5; i++) strobe(32'(i), 1'b1);
        repeat (3) tick();
        chk("t3_pulses", 64'(valid_seen - v0), 5);
        chk("t3_drained", 64'(exp_q.size()), 0);
        chk_taps("t3", 5, 4, 3, 2);

        // Overflow: fifth word with no room and no pop is dropped.
        bus.dst_accept_i = 1'b0;
        v0 = valid_seen;
        for (int i = 10; i <= 13; i++) strobe(32'(i), 1'b1);
        chk("t4_full", 64'(bus.fifo_full_o), 1);
        chk("t4_ovf_pre", 64'(bus.overflow_o), 0);
        strobe(32'd14, 1'b0);
        chk("t4_ovf", 64'(bus.overflow_o), 1);
        chk("t4_cnt", 64'(bus.fifo_cnt_o), 4);
        bus.dst_accept_i = 1'b1;
        repeat (6) tick();
        chk("t4_pulses", 64'(valid_seen - v0), 4);
        chk("t4_drained", 64'(exp_q.size()), 0);
        chk("t4_ovf_sticky", 64'(bus.overflow_o), 1);
        do_flush();
        chk("t4_ovf_flush", 64'(bus.overflow_o), 0);

        // Push and pop together while full.
        bus.dst_accept_i = 1'b0;
        v0 = valid_seen;
        for (int i = 20; i <= 23; i++) strobe(32'(i), 1'b1);
        chk("t5_full", 64'(bus.fifo_full_o), 1);
        bus.dst_accept_i = 1'b1;
        strobe(32'd24, 1'b1);
        chk("t5_cnt", 64'(bus.fifo_cnt_o), 4);
        chk("t5_ovf", 64'(bus.overflow_o), 0);
        repeat (6) tick();
        chk("t5_pulses", 64'(valid_seen - v0), 5);
        chk("t5_drained", 64'(exp_q.size()), 0);
        chk_taps("t5", 24, 23, 22, 21);

        // Stall timeout, then flush beating a simultaneous strobe.
        do_flush();
        chk("t6_tmo_clr", 64'(bus.timeout_o), 0);
        bus.dst_accept_i = 1'b0;
        strobe(32'd40, 1'b0);
        chk("t6_busy", 64'(bus.busy_o), 1);
        repeat (2) tick();
        chk("t6_tmo_early", 64'(bus.timeout_o), 0);
        repeat (3) tick();
        chk("t6_tmo", 64'(bus.timeout_o), 1);
        bus.flush_i = 1'b1;
        clear_model();
        strobe(32'd41, 1'b0);
        bus.flush_i = 1'b0;
        chk("t6_cnt", 64'(bus.fifo_cnt_o), 0);
        chk_taps("t6", 0, 0, 0, 0);
        chk("t6_tmo_flush", 64'(bus.timeout_o), 0);
        chk("t6_ovf", 64'(bus.overflow_o), 0);
        chk("t6_busy_flush", 64'(bus.busy_o), 0);
        chk("t6_valid", 64'(bus.cub_interconnect_valid_o), 0);
        bus.dst_accept_i = 1'b1;
        repeat (3) tick();
        chk("t6_cnt_after", 64'(bus.fifo_cnt_o), 0);

        // Reset mid-burst discards buffered words with no valid pulse.
        bus.dst_accept_i = 1'b0;
        for (int i = 50; i <= 52; i++) strobe(32'(i), 1'b0);
        chk("t1_cnt_pre", 64'(bus.fifo_cnt_o), 3);
        rst_n = 1'b0;
        clear_model();
        #2;
        chk_taps("t1", 0, 0, 0, 0);
        chk("t1_cnt", 64'(bus.fifo_cnt_o), 0);
        chk("t1_busy", 64'(bus.busy_o), 0);
        chk("t1_valid", 64'(bus.cub_interconnect_valid_o), 0);
        tick();
        rst_n = 1'b1;
        bus.dst_accept_i = 1'b1;
        v0 = valid_seen;
        repeat (3) tick();
        chk("t1_no_pulse", 64'(valid_seen - v0), 0);
        chk("t1_cnt_after", 64'(bus.fifo_cnt_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
